// File: rtl/rca_subtractor_seq_64bit_pkg.sv
// Shared definitions for the sequential 64-bit ripple subtractor: data width, FSM encoding
// and the CHUNK legality rule.
package rca_subtractor_seq_64bit_pkg;

  localparam int unsigned DataW = 64;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // CHUNK must split the word into whole slices.
  function automatic bit chunk_legal(int unsigned chunk);
    return (chunk >= 1) && (chunk <= DataW) && ((DataW % chunk) == 0);
  endfunction

endpackage

// File: rtl/rca_subtractor_seq_64bit_sub_chunk_stage.sv
// Combinational Width-bit ripple-carry adder slice; also exposes the carry into the top bit
// so the caller can derive signed overflow.
module sub_chunk_stage #(
  parameter int unsigned Width = 8
) (
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  input  logic             cin_i,
  output logic [Width-1:0] s_o,
  output logic             cout_o,
  output logic             c_msb_in_o
);

  logic [Width:0] carry;

  always_comb begin
    carry    = '0;
    s_o      = '0;
    carry[0] = cin_i;
    for (int i = 0; i < Width; i++) begin
      s_o[i]       = a_i[i] ^ b_i[i] ^ carry[i];
      carry[i + 1] = (a_i[i] & b_i[i]) | (a_i[i] & carry[i]) | (b_i[i] & carry[i]);
    end
  end

  assign cout_o     = carry[Width];
  assign c_msb_in_o = carry[Width-1];

endmodule

// File: rtl/rca_subtractor_seq_64bit.sv
// Multi-cycle 64-bit subtractor (diff = in1 - in2 - b_in) computed CHUNK bits per cycle.
// Optional compare flags (zero/neg/lt_signed) are enabled by defining SUB_COMPARE_FLAGS_EN.
module rca_subtractor_seq_64bit
  import rca_subtractor_seq_64bit_pkg::*;
#(
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [DataW-1:0] in1_i,
  input  logic [DataW-1:0] in2_i,
  input  logic             b_in_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [DataW-1:0] diff_o,
  output logic             b_out_o,
  output logic             overflow_o
`ifdef SUB_COMPARE_FLAGS_EN
  ,
  output logic             zero_o,
  output logic             neg_o,
  output logic             lt_signed_o
`endif
);

  localparam int unsigned N    = DataW / CHUNK;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

  if (!chunk_legal(CHUNK)) begin : g_bad_chunk
    $error("CHUNK must divide 64");
  end

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DataW-1:0]  a_q, a_d;
  logic [DataW-1:0]  b_q, b_d;
  logic              carry_q, carry_d;
  logic [DataW-1:0]  diff_q, diff_d;
  logic              b_out_q, b_out_d;
  logic              ovf_q, ovf_d;

  logic [CHUNK-1:0]  sum;
  logic              cout;
  logic              c_msb_in;
  logic [DataW-1:0]  diff_shift;
  logic              last;

  sub_chunk_stage #(
    .Width(CHUNK)
  ) u_stage (
    .a_i       (a_q[CHUNK-1:0]),
    .b_i       (b_q[CHUNK-1:0]),
    .cin_i     (carry_q),
    .s_o       (sum),
    .cout_o    (cout),
    .c_msb_in_o(c_msb_in)
  );

  // New slice enters from the MSB side so the LSB slice ends up at the bottom after N steps.
  if (CHUNK == DataW) begin : g_full
    assign diff_shift = sum;
  end else begin : g_part
    assign diff_shift = {sum, diff_q[DataW-1:CHUNK]};
  end

  assign last = (cnt_q == CntW'(N - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    diff_d  = diff_q;
    b_out_d = b_out_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          a_d     = in1_i;
          b_d     = ~in2_i;
          carry_d = ~b_in_i;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        carry_d = cout;
        diff_d  = diff_shift;
        if (last) begin
          cnt_d   = '0;
          b_out_d = ~cout;
          ovf_d   = c_msb_in ^ cout;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        if (out_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      diff_q  <= '0;
      b_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      diff_q  <= diff_d;
      b_out_q <= b_out_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef SUB_COMPARE_FLAGS_EN
  logic zero_q, neg_q, lt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
      lt_q   <= 1'b0;
    end else if (state_q == StRun && last) begin
      zero_q <= (diff_d == '0);
      neg_q  <= diff_d[DataW-1];
      lt_q   <= diff_d[DataW-1] ^ ovf_d;
    end
  end

  assign zero_o      = zero_q;
  assign neg_o       = neg_q;
  assign lt_signed_o = lt_q;
`endif

  assign in_ready_o  = (state_q == StIdle);
  assign out_valid_o = (state_q == StDone);
  assign diff_o      = diff_q;
  assign b_out_o     = b_out_q;
  assign overflow_o  = ovf_q;

endmodule
